// File: rtl/spi_master_pkg.sv
// Shared types, timing defaults and helpers for the SPI register-read master.
package spi_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ADDR,
    ST_GAP,
    ST_READ,
    ST_HOLD
  } spi_state_t;

  localparam int DLITL_DEF    = 5;
  localparam int CS_SETUP_DEF = 10;
  localparam int CS_HOLD_DEF  = 10;
  localparam int GAP_DEF      = 1;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Cycles from the cycle start is presented to the cycle done is high.
  function automatic int spi_latency(input int nbit, input int abit, input int dlitl,
                                     input int cs_setup, input int cs_hold, input int gap);
    return 1 + cs_setup + 2 * dlitl * (abit + nbit) + gap + cs_hold;
  endfunction

endpackage

// File: rtl/spi_bit_timer.sv
// Generates one sclk bit period of 2*dlitl clk cycles: low half, then high half.
module spi_bit_timer #(
  parameter int DW = 3,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_enable,
  input  logic [DW-1:0] i_dlitl,
  output logic          o_sclk,
  output logic          o_rise_tick,
  output logic          o_period_end_tick
);

  logic [CW-1:0] r_cnt;
  logic          r_sclk;
  logic [CW-1:0] w_half;
  logic [CW-1:0] w_last;

  assign w_half = CW'(i_dlitl) - CW'(1);
  assign w_last = (CW'(i_dlitl) << 1) - CW'(1);

  // Ticks mark the edge that ends the cycle, so the FSM acts in lockstep with sclk.
  assign o_rise_tick       = i_enable && (r_cnt == w_half);
  assign o_period_end_tick = i_enable && (r_cnt == w_last);
  assign o_sclk            = r_sclk;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_sclk <= 1'b0;
    end else if (!i_enable || o_period_end_tick) begin
      r_cnt  <= '0;
      r_sclk <= 1'b0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
      if (o_rise_tick) r_sclk <= 1'b1;
    end
  end

endmodule

// File: rtl/spi_master_read.sv
// SPI master issuing one register read: cs low, address out MSB-first, data in, cs high.
module spi_master_read
  import spi_master_pkg::*;
#(
  parameter int Nbit     = 32,
  parameter int ABIT     = 8,
  parameter int Dlitl    = DLITL_DEF,
  parameter int CS_SETUP = CS_SETUP_DEF,
  parameter int CS_HOLD  = CS_HOLD_DEF,
  parameter int GAP      = GAP_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [ABIT-1:0] adr,
  output logic            busy,
  output logic            done,
  output logic [Nbit-1:0] rdata,
  output logic            sclk,
  output logic            mosi,
  input  logic            miso,
  output logic            cs
);

  localparam int BCW = $clog2(imax(ABIT, Nbit) + 1);
  localparam int PCW = $clog2(imax(imax(2 * Dlitl, CS_SETUP), imax(CS_HOLD, GAP)) + 1);
  localparam int DW  = $clog2(Dlitl + 1);

  spi_state_t      r_state;
  logic [PCW-1:0]  r_pcnt;
  logic [BCW-1:0]  r_bcnt;
  logic [ABIT-1:0] r_ash;
  logic [Nbit-1:0] r_dsh;
  logic [Nbit-1:0] r_rdata;
  logic            r_miso_s1;
  logic            r_miso_s2;
  logic            r_cs;
  logic            r_mosi;
  logic            r_busy;
  logic            r_done;

  logic            w_tmr_en;
  logic            w_sclk;
  logic            w_rise;
  logic            w_pend;

  assign w_tmr_en = (r_state == ST_ADDR) || (r_state == ST_READ);

  spi_bit_timer #(
    .DW(DW),
    .CW(PCW)
  ) u_timer (
    .clk              (clk),
    .rst              (rst),
    .i_enable         (w_tmr_en),
    .i_dlitl          (DW'(Dlitl)),
    .o_sclk           (w_sclk),
    .o_rise_tick      (w_rise),
    .o_period_end_tick(w_pend)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_miso_s1 <= 1'b0;
      r_miso_s2 <= 1'b0;
    end else begin
      r_miso_s1 <= miso;
      r_miso_s2 <= r_miso_s1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_pcnt  <= '0;
      r_bcnt  <= '0;
      r_ash   <= '0;
      r_dsh   <= '0;
      r_rdata <= '0;
      r_cs    <= 1'b1;
      r_mosi  <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_ash   <= adr;
            r_dsh   <= '0;
            r_busy  <= 1'b1;
            r_cs    <= 1'b0;
            r_pcnt  <= '0;
            r_state <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (r_pcnt == PCW'(CS_SETUP - 1)) begin
            r_mosi  <= r_ash[ABIT-1];
            r_ash   <= {r_ash[ABIT-2:0], 1'b0};
            r_bcnt  <= '0;
            r_state <= ST_ADDR;
          end else begin
            r_pcnt <= r_pcnt + PCW'(1);
          end
        end
        ST_ADDR: begin
          if (w_pend) begin
            if (r_bcnt == BCW'(ABIT - 1)) begin
              r_mosi  <= 1'b1;
              r_pcnt  <= '0;
              r_state <= ST_GAP;
            end else begin
              r_mosi <= r_ash[ABIT-1];
              r_ash  <= {r_ash[ABIT-2:0], 1'b0};
              r_bcnt <= r_bcnt + BCW'(1);
            end
          end
        end
        ST_GAP: begin
          if (r_pcnt == PCW'(GAP - 1)) begin
            r_bcnt  <= '0;
            r_state <= ST_READ;
          end else begin
            r_pcnt <= r_pcnt + PCW'(1);
          end
        end
        ST_READ: begin
          if (w_rise) r_dsh <= {r_dsh[Nbit-2:0], r_miso_s2};
          if (w_pend) begin
            if (r_bcnt == BCW'(Nbit - 1)) begin
              r_pcnt  <= '0;
              r_state <= ST_HOLD;
            end else begin
              r_bcnt <= r_bcnt + BCW'(1);
            end
          end
        end
        ST_HOLD: begin
          if (r_pcnt == PCW'(CS_HOLD - 1)) begin
            r_cs    <= 1'b1;
            r_rdata <= r_dsh;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_pcnt <= r_pcnt + PCW'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign rdata = r_rdata;
  assign sclk  = w_sclk;
  assign mosi  = r_mosi;
  assign cs    = r_cs;

endmodule

// File: tb/tb_spi_master_read.sv
// Bench for spi_master_read with a behavioural register-read slave and a done scoreboard.
module tb_spi_master_read;

  localparam int LAT     = 422;
  localparam int PULSES  = 40;
  localparam int SL_ADR  = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  adr = '0;
  logic        busy, done, sclk, mosi, cs;
  logic [31:0] rdata;
  logic        miso = 1'b0;

  typedef struct {
    logic [31:0] data;
    int          cyc;
    logic [7:0]  adr;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   viol = 0;

  logic [31:0] inport = '0;
  int          sl_cnt = 0;
  int          sl_pulses = 0;
  logic [7:0]  sl_adr = '0;
  logic [7:0]  sl_adr_seen = '0;
  logic        p_cs = 1'b1;
  logic        p_sclk = 1'b0;

  spi_master_read dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .adr  (adr),
    .busy (busy),
    .done (done),
    .rdata(rdata),
    .sclk (sclk),
    .mosi (mosi),
    .miso (miso),
    .cs   (cs)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (cs && sclk) viol <= viol + 1;

  // Slave: samples mosi on sclk rise, shifts data out on sclk fall once address matches.
  always @(cs or sclk) begin
    if (cs && !p_cs) begin
      sl_pulses   = sl_cnt;
      sl_adr_seen = sl_adr;
      miso        = 1'b0;
    end
    if (!cs && p_cs) begin
      sl_cnt = 0;
      sl_adr = '0;
      miso   = 1'b0;
    end
    if (!cs && sclk && !p_sclk) begin
      if (sl_cnt < 8) sl_adr = {sl_adr[6:0], mosi};
      sl_cnt++;
    end
    if (!cs && !sclk && p_sclk) begin
      if (sl_cnt >= 8 && sl_cnt < 40 && sl_adr == 8'(SL_ADR)) miso = inport[39 - sl_cnt];
      else miso = 1'b0;
    end
    p_cs   = cs;
    p_sclk = sclk;
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) begin
        if (q.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          check("rdata", rdata, e.data);
          check("done_cycle", cyc, e.cyc);
          check("mosi_adr", sl_adr_seen, e.adr);
          check("sclk_pulses", sl_pulses, PULSES);
        end
      end
    end
  endtask

  task automatic push(input logic [31:0] d, input int c, input logic [7:0] a);
    exp_t e;
    e.data = d;
    e.cyc  = c;
    e.adr  = a;
    q.push_back(e);
  endtask

  task automatic issue(input logic [7:0] a, input logic [31:0] d, input logic [31:0] ed, input bit exp);
    @(posedge clk); #1;
    adr    = a;
    inport = d;
    start  = 1'b1;
    if (exp) push(ed, cyc + LAT, a);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int k;
    for (k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (done) break;
    end
    if (k == 1000) check({nm, "_timeout"}, 64'd0, 64'd1);
  endtask

  initial begin
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cs", cs, 1);
    check("rst_sclk", sclk, 0);
    check("rst_mosi", mosi, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rdata", rdata, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    issue(8'h01, 32'hDEEDBEEF, 32'hDEEDBEEF, 1'b1);
    @(negedge clk);
    check("busy_active", busy, 1);
    wait_done("t1");

    issue(8'h01, 32'h00000044, 32'h00000044, 1'b1);
    wait_done("t2");

    issue(8'h03, 32'hFFFFFFFF, 32'h00000000, 1'b1);
    wait_done("t3");

    // Back-to-back: start stays high through the first done.
    @(posedge clk); #1;
    adr    = 8'h01;
    inport = 32'h13579BDF;
    start  = 1'b1;
    push(32'h13579BDF, cyc + LAT, 8'h01);
    push(32'h2468ACE0, cyc + 2 * LAT, 8'h01);
    wait_done("b2b_1");
    check("b2b_cs_gap", cs, 1);
    inport = 32'h2468ACE0;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("b2b_cs_relow", cs, 0);
    wait_done("b2b_2");

    // Reset while the data phase is around bit 10.
    issue(8'h01, 32'h12345678, 32'h0, 1'b0);
    repeat (195) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_cs", cs, 1);
    check("midrst_sclk", sclk, 0);
    check("midrst_mosi", mosi, 1);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_rdata", rdata, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (50) @(posedge clk);
    issue(8'h01, 32'hA5A50FF0, 32'hA5A50FF0, 1'b1);
    wait_done("post_rst");

    // A start pulse during the address phase must be ignored.
    issue(8'h01, 32'h0BADF00D, 32'h0BADF00D, 1'b1);
    repeat (30) @(posedge clk);
    #1;
    adr   = 8'hAA;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    adr   = 8'h00;
    wait_done("ignore_start");
    repeat (LAT + 20) @(posedge clk);

    @(negedge clk);
    check("queue_empty", q.size(), 0);
    check("sclk_idle_when_cs_high", viol, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_master_read.md
Name: spi_master_read

Overview:
- SPI master that issues one register-read transaction to the SPI read-register slave block.
- Sequence: assert cs, shift out an ABIT-bit address MSB-first on mosi, clock in Nbit data bits from miso, release cs, present the word with a one-cycle done pulse.
- Sits upstream of the slave: drives its sclk/mosi/cs and consumes its miso.
- Timing matches the team's slave bench: half-period Dlitl clk cycles, cs setup/hold 10 cycles.

Parameters:
- Nbit, 32: read data width.
- ABIT, 8: address width.
- Dlitl, 5: sclk half-period in clk cycles; must be >=3.
- CS_SETUP, 10: clk cycles of cs low before first sclk period.
- CS_HOLD, 10: clk cycles of cs low after last sclk period.
- GAP, 1: clk cycles with sclk low between address and data phases.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  request; accepted when busy=0.
- adr  in  ABIT  register address; captured on acceptance.
- busy  out  1  transaction in progress.
- done  out  1  one-cycle pulse, rdata valid.
- rdata  out  Nbit  last read word; held until next done.
- sclk  out  1  SPI clock, idle low.
- mosi  out  1  SPI data out, idle high.
- miso  in  1  SPI data in; asynchronous to clk.
- cs  out  1  chip select, active-low, idle high.

Behaviour:
- Reset values (next clk after rst=1, from any state):
  - cs=1, sclk=0, mosi=1, busy=0, done=0, rdata=0.
  - FSM returns to IDLE; partial shift data is discarded.
  - rst mid-transaction must force cs high on that same next edge.
- miso passes through a 2-flop synchroniser before use.
- FSM states: IDLE, SETUP, ADDR, GAP, READ, HOLD.
- IDLE: start=1 latches adr into shift register, busy=1, goes to SETUP. start while busy is ignored.
- SETUP: cs=0 from first cycle; CS_SETUP cycles; then ADDR.
- ADDR: ABIT bit periods of 2*Dlitl cycles each.
  - mosi takes the next address bit (MSB first) at the start of each period.
  - sclk=0 for the first Dlitl cycles, sclk=1 for the next Dlitl.
  - After the last bit, mosi returns to 1.
- GAP: sclk=0 for GAP cycles; then READ.
- READ: Nbit periods with the same sclk shape.
  - Synchronised miso is shifted in MSB-first on the clk cycle where sclk goes 0->1.
- HOLD: sclk=0, cs=0 for CS_HOLD cycles.
  - Then, in the same clk edge: cs=1, rdata<=shift register, done=1 for one cycle, busy=0, back to IDLE.
- Back-to-back: start asserted in the done cycle is accepted (IDLE). cs is then high for exactly 1 cycle before the next SETUP.
- Latency: start sampled at cycle 0 gives done at cycle 1+CS_SETUP+2*Dlitl*(ABIT+Nbit)+GAP+CS_HOLD, which is 422 with defaults.
- sclk pulse count per transaction is exactly ABIT+Nbit (40). There are no sclk pulses while cs=1.
- Counters:
  - Bit counter sized clog2(max(ABIT,Nbit)+1).
  - Phase counter sized clog2(max(2*Dlitl,CS_SETUP,CS_HOLD,GAP)+1).
  - No wrap is permitted: every counter reloads on state change.

Decomposition:
- Package spi_master_pkg holds:
  - the state enum (IDLE, SETUP, ADDR, GAP, READ, HOLD);
  - default timing constants (DLITL_DEF=5, CS_SETUP_DEF=10, CS_HOLD_DEF=10);
  - a latency function for bench use.
- One sub-module, spi_bit_timer:
  - Inputs: enable, Dlitl.
  - Outputs: sclk level, rise_tick, period_end_tick.
  - The FSM consumes the ticks.

Test Plan:
- adr=1, slave param_adr=1 with inport=32'hDEEDBEEF -> rdata=32'hDEEDBEEF, done at cycle 422, mosi bits 00000001, 40 sclk pulses.
- Re-run with inport=32'h44 -> rdata=32'h00000044; cs high between transactions, sclk low whenever cs=1.
- adr=3 to slave param_adr=1 (slave keeps miso=0) -> rdata=0, done still at cycle 422.
- Back-to-back: start held high through done -> second transaction begins; cs high exactly 1 cycle; both rdata values correct.
- rst=1 during READ bit 10 -> next cycle cs=1, sclk=0, mosi=1, busy=0, rdata=0, no done. Following start completes normally.
- start pulsed during ADDR -> ignored: single done, adr unchanged on mosi.
